contador_param: RTL and testbench
=================================

CONTADOR_PARAM -- requirements
Module: contador_param

Interface
REQ-001 SHALL have parameter BITS, default 4, counter width; legal range 2..32.
REQ-002 SHALL have parameter STEP, default 3, decrement amount for mode 10; legal range 1..(2^BITS)-1.
REQ-003 SHALL have parameter SAT, default 0, overflow policy: 0 = wrap modulo 2^BITS, 1 = saturate at bounds.
REQ-004 SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-006 SHALL have port ENB, input, 1, count/load enable.
REQ-007 SHALL have port MODO, input, 2, operation select.
REQ-008 SHALL have port D, input, BITS, parallel-load data.
REQ-009 SHALL have port Q, output, BITS, registered count value.
REQ-010 SHALL have port RCO, output, 1, registered ripple-carry/terminal-event flag.

Function
REQ-011 SHALL decode MODO as 00 = up by 1, 01 = down by 1, 10 = down by STEP, 11 = parallel load of D.
REQ-012 SHALL update Q and RCO only on rising CLK edges with ENB=1 and RESET=0; with ENB=0 both SHALL hold their values.
REQ-013 SHALL have one-cycle latency: the edge that samples MODO/D/ENB produces the new Q and RCO.
REQ-014 SHALL register RCO alongside Q: RCO reflects the operation performed at the same edge, not the current Q value.
REQ-015 SHALL set RCO=1 in mode 00 iff the pre-edge Q equals 2^BITS-1; otherwise RCO=0.
REQ-016 SHALL set RCO=1 in mode 01 iff the pre-edge Q equals 0; otherwise RCO=0.
REQ-017 SHALL set RCO=1 in mode 10 iff the pre-edge Q is less than STEP; otherwise RCO=0.
REQ-018 SHALL set Q=D and RCO=1 in mode 11 as the load acknowledge.
REQ-019 SHALL, with SAT=0, compute all results modulo 2^BITS: up from max gives 0; down from 0 gives max; down-by-STEP gives Q-STEP+2^BITS when Q<STEP.
REQ-020 SHALL, with SAT=1, hold Q at 2^BITS-1 on up-overflow and at 0 on any down-underflow, including Q<STEP in mode 10; RCO SHALL still be asserted per REQ-015..017.
REQ-021 SHALL assert RCO on every enabled edge while a saturated counter stays pinned at its bound in the overflowing direction.
REQ-022 SHALL perform internal arithmetic at BITS+1 width to detect carry/borrow; there SHALL be no truncation artefacts for any legal STEP.
REQ-023 SHALL treat MODO as fully decoded; no X-holding default branch; every mode SHALL assign both next-Q and next-RCO.
REQ-024 SHALL take effect immediately on a MODO change between consecutive enabled edges, with no intermediate cycle.
REQ-025 SHALL contain no combinational path from any input to Q or RCO.

Reset
REQ-026 SHALL set Q=0 and RCO=0 at the first rising CLK edge with RESET=1, regardless of ENB, MODO or D.
REQ-027 SHALL give RESET priority over ENB and every mode, including a load or wrap occurring at the same edge.
REQ-028 SHALL resume normal operation at the first edge with RESET=0 and ENB=1, operating on Q=0.
REQ-029 SHALL leave Q and RCO undefined before the first reset edge; the bench SHALL apply reset first.

Verification (BITS=4, STEP=3, SAT=0 unless stated)
REQ-030 Reset: RESET=1, ENB=1, MODO=11, D=9 for one edge -> Q=0, RCO=0; hold RESET=1 with ENB=0 -> Q=0, RCO=0.
REQ-031 Up wrap: load D=14 -> Q=14, RCO=1; MODO=00 -> Q=15, RCO=0; next edge -> Q=0, RCO=1; next edge -> Q=1, RCO=0.
REQ-032 Down and down-by-3: load 2, MODO=10 -> Q=15, RCO=1; next edge -> Q=12, RCO=0; MODO=01 from Q=0 -> Q=15, RCO=1.
REQ-033 Saturate (SAT=1): load 1, MODO=10 -> Q=0, RCO=1; repeat -> Q=0, RCO=1; load 15, MODO=00 -> Q=15, RCO=1.
REQ-034 Enable/reset interplay: Q=7, ENB=0, toggle MODO/D for 5 edges -> Q=7 and RCO unchanged; assert RESET with ENB=0 -> Q=0, RCO=0.
REQ-035 Width/step generality (BITS=8, STEP=5): load 0xFF, MODO=00 -> Q=0x00, RCO=1; load 4, MODO=10 -> Q=0xFF, RCO=1; load 5, MODO=10 -> Q=0x00, RCO=0.

Source files
------------

// File: rtl/contador_param.sv
// contador_param: parameterised up/down/step/load counter with registered ripple-carry flag
module contador_param #(
   parameter int BITS = 4,
   parameter int STEP = 3,
   parameter int SAT  = 0
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            ENB,
   input  logic [1:0]      MODO,
   input  logic [BITS-1:0] D,
   output logic [BITS-1:0] Q,
   output logic            RCO
);
   localparam logic [BITS:0] STEP_W = (BITS+1)'(STEP);
   logic [BITS:0]   up, dn1, dns;
   logic [BITS-1:0] nq;
   logic            nrco;
   // The extra top bit of each result is the carry/borrow out of the BITS-wide count
   always_comb begin
      up   = {1'b0, Q} + 1'b1;
      dn1  = {1'b0, Q} - 1'b1;
      dns  = {1'b0, Q} - STEP_W;
      nq   = MODO == 2'b11 ? D :
             MODO == 2'b10 ? ((dns[BITS] && SAT != 0) ? '0 : dns[BITS-1:0]) :
             MODO == 2'b01 ? ((dn1[BITS] && SAT != 0) ? '0 : dn1[BITS-1:0]) :
                             ((up[BITS]  && SAT != 0) ? '1 : up[BITS-1:0]);
      nrco = MODO == 2'b11 ? 1'b1 :
             MODO == 2'b10 ? dns[BITS] :
             MODO == 2'b01 ? dn1[BITS] : up[BITS];
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         Q   <= '0;
         RCO <= 1'b0;
      end else if (ENB) begin
         Q   <= nq;
         RCO <= nrco;
      end
   end
endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: directed checks of wrap, saturate and wide/step counter variants
module tb_contador_param;
   logic       CLK = 1'b0;
   logic       RESET = 1'b0, ENB = 1'b0;
   logic [1:0] MODO = 2'b00;
   logic [3:0] d4 = '0;
   logic [7:0] d8 = '0;
   logic [3:0] q0, q1;
   logic [7:0] q2;
   logic       r0, r1, r2;
   int tests = 0, fails = 0;

   always #5 CLK = ~CLK;

   contador_param #(.BITS(4), .STEP(3), .SAT(0)) dut_wrap (
      .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .D(d4), .Q(q0), .RCO(r0));
   contador_param #(.BITS(4), .STEP(3), .SAT(1)) dut_sat (
      .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .D(d4), .Q(q1), .RCO(r1));
   contador_param #(.BITS(8), .STEP(5), .SAT(0)) dut_wide (
      .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .D(d8), .Q(q2), .RCO(r2));

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RESET = 1'b1; ENB = 1'b1; MODO = 2'b11; d4 = 4'd9; d8 = 8'd9;
      tick();
      tests++; if (q0 !== 4'd0 || r0 !== 1'b0) begin fails++; $display("FAIL reset_wrap q=%0d rco=%0b exp 0/0", q0, r0); end
      tests++; if (q1 !== 4'd0 || r1 !== 1'b0) begin fails++; $display("FAIL reset_sat q=%0d rco=%0b exp 0/0", q1, r1); end
      tests++; if (q2 !== 8'd0 || r2 !== 1'b0) begin fails++; $display("FAIL reset_wide q=%0d rco=%0b exp 0/0", q2, r2); end
      ENB = 1'b0;
      tick();
      tests++; if (q0 !== 4'd0 || r0 !== 1'b0) begin fails++; $display("FAIL reset_hold q=%0d rco=%0b exp 0/0", q0, r0); end
      RESET = 1'b0; ENB = 1'b1;
   endtask

   task automatic test_up_wrap();
      MODO = 2'b11; d4 = 4'd14;
      tick();
      tests++; if (q0 !== 4'd14 || r0 !== 1'b1) begin fails++; $display("FAIL up_load q=%0d rco=%0b exp 14/1", q0, r0); end
      MODO = 2'b00;
      tick();
      tests++; if (q0 !== 4'd15 || r0 !== 1'b0) begin fails++; $display("FAIL up_15 q=%0d rco=%0b exp 15/0", q0, r0); end
      tick();
      tests++; if (q0 !== 4'd0 || r0 !== 1'b1) begin fails++; $display("FAIL up_wrap q=%0d rco=%0b exp 0/1", q0, r0); end
      tick();
      tests++; if (q0 !== 4'd1 || r0 !== 1'b0) begin fails++; $display("FAIL up_1 q=%0d rco=%0b exp 1/0", q0, r0); end
   endtask

   task automatic test_down_step();
      MODO = 2'b11; d4 = 4'd2;
      tick();
      MODO = 2'b10;
      tick();
      tests++; if (q0 !== 4'd15 || r0 !== 1'b1) begin fails++; $display("FAIL step_wrap q=%0d rco=%0b exp 15/1", q0, r0); end
      tick();
      tests++; if (q0 !== 4'd12 || r0 !== 1'b0) begin fails++; $display("FAIL step_12 q=%0d rco=%0b exp 12/0", q0, r0); end
      MODO = 2'b11; d4 = 4'd0;
      tick();
      MODO = 2'b01;
      tick();
      tests++; if (q0 !== 4'd15 || r0 !== 1'b1) begin fails++; $display("FAIL down_wrap q=%0d rco=%0b exp 15/1", q0, r0); end
      tick();
      tests++; if (q0 !== 4'd14 || r0 !== 1'b0) begin fails++; $display("FAIL down_14 q=%0d rco=%0b exp 14/0", q0, r0); end
   endtask

   task automatic test_back_to_back();
      MODO = 2'b00;
      tick();
      tests++; if (q0 !== 4'd15 || r0 !== 1'b0) begin fails++; $display("FAIL b2b_up q=%0d rco=%0b exp 15/0", q0, r0); end
      MODO = 2'b10;
      tick();
      tests++; if (q0 !== 4'd12 || r0 !== 1'b0) begin fails++; $display("FAIL b2b_step q=%0d rco=%0b exp 12/0", q0, r0); end
      MODO = 2'b01;
      tick();
      tests++; if (q0 !== 4'd11 || r0 !== 1'b0) begin fails++; $display("FAIL b2b_down q=%0d rco=%0b exp 11/0", q0, r0); end
   endtask

   task automatic test_saturate();
      MODO = 2'b11; d4 = 4'd1;
      tick();
      MODO = 2'b10;
      tick();
      tests++; if (q1 !== 4'd0 || r1 !== 1'b1) begin fails++; $display("FAIL sat_step q=%0d rco=%0b exp 0/1", q1, r1); end
      tick();
      tests++; if (q1 !== 4'd0 || r1 !== 1'b1) begin fails++; $display("FAIL sat_step_pin q=%0d rco=%0b exp 0/1", q1, r1); end
      MODO = 2'b01;
      tick();
      tests++; if (q1 !== 4'd0 || r1 !== 1'b1) begin fails++; $display("FAIL sat_down_pin q=%0d rco=%0b exp 0/1", q1, r1); end
      MODO = 2'b11; d4 = 4'd15;
      tick();
      MODO = 2'b00;
      tick();
      tests++; if (q1 !== 4'd15 || r1 !== 1'b1) begin fails++; $display("FAIL sat_up q=%0d rco=%0b exp 15/1", q1, r1); end
      tick();
      tests++; if (q1 !== 4'd15 || r1 !== 1'b1) begin fails++; $display("FAIL sat_up_pin q=%0d rco=%0b exp 15/1", q1, r1); end
      MODO = 2'b11; d4 = 4'd9;
      tick();
      MODO = 2'b10;
      tick();
      tests++; if (q1 !== 4'd6 || r1 !== 1'b0) begin fails++; $display("FAIL sat_step_norm q=%0d rco=%0b exp 6/0", q1, r1); end
   endtask

   task automatic test_enable();
      MODO = 2'b11; d4 = 4'd7;
      tick();
      ENB = 1'b0;
      for (int i = 0; i < 5; i++) begin
         MODO = 2'(i); d4 = 4'(i + 3);
         tick();
         tests++; if (q0 !== 4'd7 || r0 !== 1'b1) begin fails++; $display("FAIL enb_hold%0d q=%0d rco=%0b exp 7/1", i, q0, r0); end
      end
      RESET = 1'b1;
      tick();
      tests++; if (q0 !== 4'd0 || r0 !== 1'b0) begin fails++; $display("FAIL enb_reset q=%0d rco=%0b exp 0/0", q0, r0); end
      RESET = 1'b0; ENB = 1'b1;
   endtask

   task automatic test_reset_priority();
      MODO = 2'b11; d4 = 4'd15;
      tick();
      RESET = 1'b1; MODO = 2'b00;
      tick();
      tests++; if (q0 !== 4'd0 || r0 !== 1'b0) begin fails++; $display("FAIL rst_prio q=%0d rco=%0b exp 0/0", q0, r0); end
      RESET = 1'b0;
      tick();
      tests++; if (q0 !== 4'd1 || r0 !== 1'b0) begin fails++; $display("FAIL rst_resume q=%0d rco=%0b exp 1/0", q0, r0); end
   endtask

   task automatic test_wide();
      MODO = 2'b11; d8 = 8'hFF;
      tick();
      MODO = 2'b00;
      tick();
      tests++; if (q2 !== 8'h00 || r2 !== 1'b1) begin fails++; $display("FAIL wide_up q=%0h rco=%0b exp 00/1", q2, r2); end
      MODO = 2'b11; d8 = 8'd4;
      tick();
      MODO = 2'b10;
      tick();
      tests++; if (q2 !== 8'hFF || r2 !== 1'b1) begin fails++; $display("FAIL wide_step_wrap q=%0h rco=%0b exp ff/1", q2, r2); end
      MODO = 2'b11; d8 = 8'd5;
      tick();
      MODO = 2'b10;
      tick();
      tests++; if (q2 !== 8'h00 || r2 !== 1'b0) begin fails++; $display("FAIL wide_step_exact q=%0h rco=%0b exp 00/0", q2, r2); end
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_step();
      test_back_to_back();
      test_saturate();
      test_enable();
      test_reset_priority();
      test_wide();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
